// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the rv32i core: fetch, decode, execute, memory and writeback,
// with traps for illegal opcodes, bus timeouts and ECALL/EBREAK.
//
// state     | meaning
// FETCH     | request instruction, wait for imem_ready
// DECODE    | latch opcode/funct3, screen for illegal and ECALL/EBREAK
// EXECUTE   | ALU step; branches, FENCE and CSR retire here
// MEM       | hold load/store strobe until dmem_ready
// WRITEBACK | register write and PC update, retire
// TRAP      | halted with cause until reset
module cpu_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [3:0]  inst_type,
    input  logic        opcode_valid,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_load,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        alu_src_b,
    output logic        alu_src_a_pc,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
        S_MEM = 3'd3, S_WRITEBACK = 3'd4, S_TRAP = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_IMM = 7'b0010011, OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [7:0] C_TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [6:0]  r_opc;
    logic [2:0]  r_f3;
    logic [7:0]  r_cnt;
    logic [1:0]  r_cause, w_cause_nxt;
    logic [31:0] r_instret;
    logic        w_cnt_inc, w_retire;
    logic        w_unused_ok;

    // Instruction class is derived from the opcode itself; the decoder's type field is redundant here.
    assign w_unused_ok = ^inst_type;

    logic w_is_load, w_is_store, w_is_nop, w_imm_b, w_pc_a;
    assign w_is_load  = (r_opc == OP_LOAD);
    assign w_is_store = (r_opc == OP_STORE);
    assign w_is_nop   = (r_opc == OP_FENCE) || ((r_opc == OP_SYSTEM) && (r_f3 != 3'd0));
    assign w_imm_b    = (r_opc == OP_IMM) || w_is_load || (r_opc == OP_JALR) || w_is_store
                     || (r_opc == OP_LUI) || (r_opc == OP_AUIPC) || (r_opc == OP_JAL);
    assign w_pc_a     = (r_opc == OP_AUIPC) || (r_opc == OP_JAL) || (r_opc == OP_JALR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_opc     <= 7'd0;
            r_f3      <= 3'd0;
            r_cnt     <= 8'd0;
            r_cause   <= 2'd0;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause_nxt;
            if (w_next != r_state)
                r_cnt <= 8'd0;
            else if (w_cnt_inc)
                r_cnt <= r_cnt + 8'd1;
            if (r_state == S_DECODE) begin
                r_opc <= opcode;
                r_f3  <= funct3;
            end
            if (w_retire)
                r_instret <= r_instret + 32'd1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cause_nxt  = r_cause;
        w_cnt_inc    = 1'b0;
        w_retire     = 1'b0;
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 2'd0;
        alu_src_b    = 1'b0;
        alu_src_a_pc = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    w_next  = S_DECODE;
                end else if (r_cnt == C_TO_LAST) begin
                    w_next      = S_TRAP;
                    w_cause_nxt = 2'd2;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_DECODE: begin
                if (!opcode_valid) begin
                    w_next      = S_TRAP;
                    w_cause_nxt = 2'd1;
                end else if ((opcode == OP_SYSTEM) && (funct3 == 3'd0)) begin
                    w_next      = S_TRAP;
                    w_cause_nxt = 2'd3;
                end else begin
                    w_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                alu_src_b    = w_imm_b;
                alu_src_a_pc = w_pc_a;
                if (w_is_load || w_is_store) begin
                    w_next = S_MEM;
                end else if (r_opc == OP_BRANCH) begin
                    pc_write = 1'b1;
                    pc_sel   = {1'b0, branch_taken};
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_is_nop) begin
                    pc_write = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    w_next = S_WRITEBACK;
                end
            end
            S_MEM: begin
                alu_src_b = 1'b1;
                mem_read  = w_is_load;
                mem_write = w_is_store;
                if (dmem_ready) begin
                    if (w_is_load) begin
                        w_next = S_WRITEBACK;
                    end else begin
                        pc_write = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end else if (r_cnt == C_TO_LAST) begin
                    w_next      = S_TRAP;
                    w_cause_nxt = 2'd2;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_WRITEBACK: begin
                reg_write    = 1'b1;
                pc_write     = 1'b1;
                alu_src_b    = w_imm_b;
                alu_src_a_pc = w_pc_a;
                if (r_opc == OP_LUI)
                    wb_sel = 2'd3;
                else if ((r_opc == OP_JAL) || (r_opc == OP_JALR))
                    wb_sel = 2'd2;
                else if (w_is_load)
                    wb_sel = 2'd1;
                if (r_opc == OP_JAL)
                    pc_sel = 2'd1;
                else if (r_opc == OP_JALR)
                    pc_sel = 2'd2;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP: ;
            default: w_next = S_FETCH;
        endcase
        // An instruction caught by reset must not touch architectural state in the reset cycle.
        if (rst) begin
            w_retire     = 1'b0;
            imem_req     = 1'b0;
            ir_load      = 1'b0;
            pc_write     = 1'b0;
            pc_sel       = 2'd0;
            alu_src_b    = 1'b0;
            alu_src_a_pc = 1'b0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            reg_write    = 1'b0;
            wb_sel       = 2'd0;
        end
    end

    assign state      = r_state;
    assign trap       = (r_state == S_TRAP) && !rst;
    assign trap_cause = r_cause;
    assign instret    = r_instret;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: instruction walks, traps, timeouts, reset abort and instret wrap.
module tb_cpu_control_fsm;
    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [3:0]  inst_type;
    logic        opcode_valid, branch_taken, imem_ready, dmem_ready;
    logic        imem_req, ir_load, pc_write, alu_src_b, alu_src_a_pc;
    logic        mem_read, mem_write, reg_write, trap;
    logic [1:0]  pc_sel, wb_sel, trap_cause;
    logic [2:0]  state;
    logic [31:0] instret;
    int          total = 0;
    int          bad = 0;

    cpu_control_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .inst_type(inst_type),
        .opcode_valid(opcode_valid), .branch_taken(branch_taken), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_load(ir_load), .pc_write(pc_write),
        .pc_sel(pc_sel), .alu_src_b(alu_src_b), .alu_src_a_pc(alu_src_a_pc),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .wb_sel(wb_sel),
        .state(state), .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Presents an instruction with imem_ready on the first FETCH cycle; returns with the DUT in DECODE.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic v);
        opcode = op; funct3 = f3; opcode_valid = v; imem_ready = 1'b1;
        #1;
        chk("fetch_ir_load", 32'(ir_load), 32'd1);
        step();
        imem_ready = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    logic [6:0] jop [3];
    logic [1:0] jwb [3];
    logic [1:0] jpc [3];
    int n;

    initial begin
        rst = 1'b1; opcode = '0; funct3 = '0; inst_type = '0; opcode_valid = 1'b0;
        branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        step(); step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        rst = 1'b0;
        #1;
        chk("fetch_req", 32'(imem_req), 32'd1);

        // ADDI x1,x0,5
        issue(7'h13, 3'd0, 1'b1);
        chk("addi_decode", 32'(state), 32'd1);
        step();
        chk("addi_exec", 32'(state), 32'd2);
        chk("addi_exec_srcb", 32'(alu_src_b), 32'd1);
        step();
        chk("addi_wb", 32'(state), 32'd4);
        chk("addi_wb_regw", 32'(reg_write), 32'd1);
        chk("addi_wb_pcw", 32'(pc_write), 32'd1);
        chk("addi_wb_sel", 32'(wb_sel), 32'd0);
        chk("addi_wb_pcsel", 32'(pc_sel), 32'd0);
        chk("addi_wb_srcb", 32'(alu_src_b), 32'd1);
        chk("addi_wb_instret", instret, 32'd0);
        step();
        chk("addi_done_state", 32'(state), 32'd0);
        chk("addi_instret", instret, 32'd1);

        // LW, dmem_ready on the third MEM cycle
        issue(7'h03, 3'd2, 1'b1);
        step();
        chk("lw_exec_srcb", 32'(alu_src_b), 32'd1);
        step();
        chk("lw_mem1_rd", 32'(mem_read), 32'd1);
        chk("lw_mem1_wr", 32'(mem_write), 32'd0);
        step();
        chk("lw_mem2_rd", 32'(mem_read), 32'd1);
        step();
        dmem_ready = 1'b1;
        #1;
        chk("lw_mem3_rd", 32'(mem_read), 32'd1);
        chk("lw_mem3_state", 32'(state), 32'd3);
        step();
        dmem_ready = 1'b0;
        #1;
        chk("lw_wb_state", 32'(state), 32'd4);
        chk("lw_wb_rd", 32'(mem_read), 32'd0);
        chk("lw_wb_sel", 32'(wb_sel), 32'd1);
        chk("lw_wb_regw", 32'(reg_write), 32'd1);
        step();
        chk("lw_instret", instret, 32'd2);

        // BEQ taken
        issue(7'h63, 3'd0, 1'b1);
        branch_taken = 1'b1;
        step();
        chk("beq_exec_pcw", 32'(pc_write), 32'd1);
        chk("beq_exec_pcsel", 32'(pc_sel), 32'd1);
        chk("beq_exec_regw", 32'(reg_write), 32'd0);
        step();
        branch_taken = 1'b0;
        chk("beq_back_fetch", 32'(state), 32'd0);
        chk("beq_instret", instret, 32'd3);

        // JAL, JALR, LUI writeback selects
        jop[0] = 7'h6F; jwb[0] = 2'd2; jpc[0] = 2'd1;
        jop[1] = 7'h67; jwb[1] = 2'd2; jpc[1] = 2'd2;
        jop[2] = 7'h37; jwb[2] = 2'd3; jpc[2] = 2'd0;
        for (int i = 0; i < 3; i++) begin
            issue(jop[i], 3'd0, 1'b1);
            step();
            step();
            chk($sformatf("jwb%0d_wb_sel", i), 32'(wb_sel), 32'(jwb[i]));
            chk($sformatf("jwb%0d_pc_sel", i), 32'(pc_sel), 32'(jpc[i]));
            step();
        end
        chk("j_instret", instret, 32'd6);

        // Illegal opcode
        issue(7'h7F, 3'd0, 1'b0);
        step();
        chk("ill_state", 32'(state), 32'd5);
        chk("ill_trap", 32'(trap), 32'd1);
        chk("ill_cause", 32'(trap_cause), 32'd1);
        chk("ill_instret", instret, 32'd6);
        repeat (20) step();
        chk("ill_hold_trap", 32'(trap), 32'd1);
        chk("ill_hold_req", 32'(imem_req), 32'd0);
        do_reset();
        chk("ill_rst_state", 32'(state), 32'd0);
        chk("ill_rst_trap", 32'(trap), 32'd0);

        // Fetch timeout
        opcode_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && state == 3'd0; i++) begin
            if (imem_req) n++;
            step();
        end
        chk("fto_cycles", 32'(n), 32'd16);
        chk("fto_state", 32'(state), 32'd5);
        chk("fto_cause", 32'(trap_cause), 32'd2);
        do_reset();

        // Store timeout
        issue(7'h23, 3'd2, 1'b1);
        step();
        step();
        chk("sto_mem_rd", 32'(mem_read), 32'd0);
        n = 0;
        for (int i = 0; i < 40 && state == 3'd3; i++) begin
            if (mem_write) n++;
            step();
        end
        chk("sto_cycles", 32'(n), 32'd16);
        chk("sto_state", 32'(state), 32'd5);
        chk("sto_cause", 32'(trap_cause), 32'd2);
        chk("sto_wr_off", 32'(mem_write), 32'd0);
        chk("sto_instret", instret, 32'd0);
        do_reset();

        // ECALL
        issue(7'h73, 3'd0, 1'b1);
        step();
        chk("ecall_state", 32'(state), 32'd5);
        chk("ecall_cause", 32'(trap_cause), 32'd3);
        do_reset();

        // Reset while a load is in MEM
        issue(7'h03, 3'd2, 1'b1);
        step();
        step();
        rst = 1'b1;
        dmem_ready = 1'b1;
        #1;
        chk("rmem_regw0", 32'(reg_write), 32'd0);
        chk("rmem_pcw0", 32'(pc_write), 32'd0);
        step();
        rst = 1'b0;
        dmem_ready = 1'b0;
        #1;
        chk("rmem_state", 32'(state), 32'd0);
        chk("rmem_regw1", 32'(reg_write), 32'd0);
        chk("rmem_pcw1", 32'(pc_write), 32'd0);

        // instret wrap
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        #1;
        chk("wrap_pre", instret, 32'hFFFF_FFFF);
        issue(7'h13, 3'd0, 1'b1);
        step();
        step();
        step();
        chk("wrap_state", 32'(state), 32'd0);
        chk("wrap_instret", instret, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
